seq_div_16b: RTL and testbench



---
 rtl/seq_div_pkg.sv | 26 ++
 rtl/seq_div_16b_div_step.sv | 46 ++++
 rtl/seq_div_16b.sv | 186 ++++++++++++++++++
 tb/tb_seq_div_16b.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
// Shared definitions for the sequential restoring divider:
//   - div_state_e   : controller states (IDLE, RUN, DONE)
//   - DIV_WIDTH_DEF : default operand/result width
//   - cnt_width()   : iteration counter width for a given operand width
//   - DIV_CNT_W     : counter width for the default operand width
// -----------------------------------------------------------------------------
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH_DEF = 16;

    // One extra bit so the counter can also hold WIDTH itself (sign fix-up cycle).
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH_DEF);

endpackage

// File: rtl/seq_div_16b_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational iteration of the restoring divider.
//   i_r       [WIDTH:0]   partial remainder before the step
//   i_q       [WIDTH-1:0] quotient/dividend shift register before the step
//   i_divisor [WIDTH-1:0] divisor (magnitude)
//   o_r       [WIDTH:0]   partial remainder after the step
//   o_q       [WIDTH-1:0] shift register after the step, new quotient bit in [0]
// The trial subtraction is built as R + ~{0,divisor} + 1; a missing carry-out
// is a borrow, meaning the trial went negative and R is restored.
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_r,
    output logic [WIDTH-1:0] o_q
);

    localparam int SUM_W = WIDTH + 2;

    logic [WIDTH:0] w_shift_r;
    logic [WIDTH:0] w_inv_div;
    logic [WIDTH:0] w_trial;
    logic           w_carry;
    logic           w_borrow;
    logic           w_unused_r_msb;

    // The stored remainder is always below the divisor, so its top bit is
    // zero and is shifted out without loss.
    assign w_unused_r_msb = i_r[WIDTH];

    assign w_shift_r = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
    assign w_inv_div = ~{1'b0, i_divisor};

    assign {w_carry, w_trial} = {1'b0, w_shift_r} + {1'b0, w_inv_div} + SUM_W'(1);

    // With R < divisor the borrow equals the sign bit of the trial result.
    assign w_borrow = ~w_carry;

    assign o_r = w_borrow ? w_shift_r : w_trial;
    assign o_q = {i_q[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/seq_div_16b.sv
// -----------------------------------------------------------------------------
// seq_div_16b
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One quotient bit is produced per clock; results are held until the next
// accepted start.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled in IDLE and DONE only
//   signed_mode  (SEQ_DIV_SIGNED_EN builds only) two's-complement operands
//   dividend     numerator, captured on accepted start
//   divisor      denominator, captured on accepted start
//   busy         high while iterating
//   done         one-cycle pulse, results valid from this cycle
//   quotient     result
//   remainder    result
//   div_by_zero  set with done when divisor was zero
//
// Build option: define SEQ_DIV_SIGNED_EN to add signed_mode. Signed operands
// are divided as magnitudes and fixed up in one extra RUN cycle.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating (plus the sign fix-up cycle in signed mode)
// DONE  | done pulse; start accepted here as in IDLE
// -----------------------------------------------------------------------------
module seq_div_16b
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic             signed_mode,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       r_state;
    div_state_e       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic             w_iter;
    logic             w_div_zero;
    logic [WIDTH:0]   w_r_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_res_q;
    logic [WIDTH-1:0] w_res_r;

    assign w_div_zero = (divisor == '0);

`ifdef SEQ_DIV_SIGNED_EN
    logic r_sgn;
    logic r_neg_q;
    logic r_neg_r;

    assign w_op_a = (signed_mode && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
    assign w_op_b = (signed_mode && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;

    // Signed runs spend count==WIDTH on the fix-up instead of an iteration.
    assign w_iter  = (r_cnt != CNT_W'(WIDTH));
    assign w_last  = r_sgn ? (r_cnt == CNT_W'(WIDTH)) : (r_cnt == CNT_W'(WIDTH - 1));
    assign w_res_q = r_sgn ? (r_neg_q ? (~r_q + WIDTH'(1)) : r_q) : w_q_nx;
    assign w_res_r = r_sgn ? (r_neg_r ? (~r_r[WIDTH-1:0] + WIDTH'(1)) : r_r[WIDTH-1:0])
                           : w_r_nx[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sgn   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_sgn   <= signed_mode;
            r_neg_q <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= signed_mode & dividend[WIDTH-1];
        end
    end
`else
    assign w_op_a  = dividend;
    assign w_op_b  = divisor;
    assign w_iter  = 1'b1;
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_res_q = w_q_nx;
    assign w_res_r = w_r_nx[WIDTH-1:0];
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_r       (r_r),
        .i_q       (r_q),
        .i_divisor (r_div),
        .o_r       (w_r_nx),
        .o_q       (w_q_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_div_zero ? DONE : RUN;
                end else if (r_state == DONE) begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_r    <= '0;
            r_q    <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_r   <= '0;
            r_q   <= w_op_a;
            r_div <= w_op_b;
            r_dbz <= w_div_zero;
            // Divide-by-zero skips RUN, so its results are published here.
            if (w_div_zero) begin
                r_quot <= '1;
                r_rem  <= dividend;
            end
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_iter) begin
                r_r <= w_r_nx;
                r_q <= w_q_nx;
            end
            if (w_last) begin
                r_quot <= w_res_q;
                r_rem  <= w_res_r;
            end
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div_16b.sv
// -----------------------------------------------------------------------------
// tb_seq_div_16b
// Directed-vector bench for seq_div_16b with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_seq_div_16b;

    localparam int W = 16;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         start    = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor  = '0;
`ifdef SEQ_DIV_SIGNED_EN
    logic         signed_mode = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_div_16b dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef SEQ_DIV_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Presents a request for one cycle; returns #1 after the accepting edge.
    // Operands are scrambled afterwards so only the captured copies matter.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Counts edges until done is seen (lat = -1 on timeout) and busy samples.
    task automatic wait_done(input int max_edges, output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int k = 0; k <= max_edges; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy === 1'b1) busy_n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_n,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output logic done_after);
        issue(a, b);
        wait_done(40, lat, busy_n);
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({busy, done, div_by_zero} !== 3'b000)
            $display("FAIL reset_flags: got busy/done/dbz=%b required 000", {busy, done, div_by_zero});
        else n_pass++;
        n_checks++;
        if ({quotient, remainder} !== 32'h0)
            $display("FAIL reset_results: got q=%h r=%h required 0000/0000", quotient, remainder);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bn;
        logic [W-1:0] q, r;
        logic dz, da;
        run_op(16'd100, 16'd7, lat, bn, q, r, dz, da);
        n_checks++;
        if (lat !== 16) $display("FAIL basic_latency: got %0d edges required 16", lat);
        else n_pass++;
        n_checks++;
        if (bn !== 16) $display("FAIL basic_busy_cycles: got %0d required 16", bn);
        else n_pass++;
        n_checks++;
        if (q !== 16'd14) $display("FAIL basic_quotient: got %0d required 14", q);
        else n_pass++;
        n_checks++;
        if (r !== 16'd2) $display("FAIL basic_remainder: got %0d required 2", r);
        else n_pass++;
        n_checks++;
        if (dz !== 1'b0) $display("FAIL basic_dbz: got %b required 0", dz);
        else n_pass++;
        n_checks++;
        if (da !== 1'b0) $display("FAIL basic_done_pulse_width: done still %b one cycle later, required 0", da);
        else n_pass++;
    endtask

    task automatic test_boundary();
        int lat, bn;
        logic [W-1:0] q, r;
        logic dz, da;
        run_op(16'hFFFF, 16'h0001, lat, bn, q, r, dz, da);
        n_checks++;
        if ({q, r} !== {16'hFFFF, 16'h0000})
            $display("FAIL max_by_one: got q=%h r=%h required ffff/0000", q, r);
        else n_pass++;
        n_checks++;
        if (lat !== 16) $display("FAIL max_by_one_latency: got %0d required 16", lat);
        else n_pass++;
        run_op(16'h0003, 16'h000A, lat, bn, q, r, dz, da);
        n_checks++;
        if ({q, r} !== {16'h0000, 16'h0003})
            $display("FAIL small_by_large: got q=%h r=%h required 0000/0003", q, r);
        else n_pass++;
    endtask

    task automatic test_div_zero();
        int lat, bn;
        logic [W-1:0] q, r;
        logic dz, da;
        run_op(16'd5, 16'd0, lat, bn, q, r, dz, da);
        n_checks++;
        if (!(lat == 0 || lat == 1)) $display("FAIL dbz_latency: got %0d edges required 0 or 1", lat);
        else n_pass++;
        n_checks++;
        if (bn !== 0) $display("FAIL dbz_busy: got %0d busy cycles required 0", bn);
        else n_pass++;
        n_checks++;
        if ({q, r, dz} !== {16'hFFFF, 16'd5, 1'b1})
            $display("FAIL dbz_result: got q=%h r=%h dbz=%b required ffff/0005/1", q, r, dz);
        else n_pass++;
        n_checks++;
        if (da !== 1'b0) $display("FAIL dbz_done_pulse_width: got %b required 0", da);
        else n_pass++;
        issue(16'd9, 16'd3);
        n_checks++;
        if (div_by_zero !== 1'b0) $display("FAIL dbz_clear_on_start: got %b required 0", div_by_zero);
        else n_pass++;
        wait_done(40, lat, bn);
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {16'd3, 16'd0, 1'b0})
            $display("FAIL after_dbz: got q=%h r=%h dbz=%b required 0003/0000/0", quotient, remainder, div_by_zero);
        else n_pass++;
        n_checks++;
        if (lat !== 16) $display("FAIL after_dbz_latency: got %0d required 16", lat);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_ignore();
        int lat, bn;
        issue(16'd1000, 16'd10);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if ({busy, quotient} !== {1'b1, 16'd3})
            $display("FAIL hold_during_run: got busy=%b q=%h required 1/0003", busy, quotient);
        else n_pass++;
        wait_done(30, lat, bn);
        n_checks++;
        if (lat !== 10) $display("FAIL ignore_latency: got %0d remaining edges required 10", lat);
        else n_pass++;
        n_checks++;
        if ({quotient, remainder} !== {16'd100, 16'd0})
            $display("FAIL ignore_result: got q=%0d r=%0d required 100/0", quotient, remainder);
        else n_pass++;
    endtask

    // Entered in the DONE cycle left by test_busy_ignore.
    task automatic test_back_to_back();
        int lat, bn;
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if ({busy, done, quotient} !== {1'b1, 1'b0, 16'd100})
            $display("FAIL b2b_accept: got busy=%b done=%b q=%0d required 1/0/100", busy, done, quotient);
        else n_pass++;
        wait_done(40, lat, bn);
        n_checks++;
        if (lat !== 16) $display("FAIL b2b_latency: got %0d required 16", lat);
        else n_pass++;
        n_checks++;
        if ({quotient, remainder} !== {16'd10, 16'd0})
            $display("FAIL b2b_result: got q=%0d r=%0d required 10/0", quotient, remainder);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat, bn;
        int done_seen;
        logic [W-1:0] q, r;
        logic dz, da;
        issue(16'd1000, 16'd10);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'h0)
            $display("FAIL mid_reset: got busy=%b done=%b dbz=%b q=%h r=%h required all zero",
                     busy, done, div_by_zero, quotient, remainder);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        n_checks++;
        if (done_seen !== 0) $display("FAIL mid_reset_no_done: got %0d active cycles required 0", done_seen);
        else n_pass++;
        run_op(16'd20, 16'd6, lat, bn, q, r, dz, da);
        n_checks++;
        if ({q, r, lat} !== {16'd3, 16'd2, 32'd16})
            $display("FAIL post_reset: got q=%0d r=%0d lat=%0d required 3/2/16", q, r, lat);
        else n_pass++;
    endtask

`ifdef SEQ_DIV_SIGNED_EN
    task automatic test_signed();
        int lat, bn;
        logic [W-1:0] q, r;
        logic dz, da;
        signed_mode = 1'b1;
        run_op(16'hFFF9, 16'h0002, lat, bn, q, r, dz, da);
        n_checks++;
        if ({q, r, dz} !== {16'hFFFD, 16'hFFFF, 1'b0})
            $display("FAIL signed_neg7_by_2: got q=%h r=%h dbz=%b required fffd/ffff/0", q, r, dz);
        else n_pass++;
        n_checks++;
        if (lat !== 17) $display("FAIL signed_latency: got %0d required 17", lat);
        else n_pass++;
        run_op(16'h8000, 16'hFFFF, lat, bn, q, r, dz, da);
        n_checks++;
        if ({q, r, dz} !== {16'h8000, 16'h0000, 1'b0})
            $display("FAIL signed_min_by_neg1: got q=%h r=%h dbz=%b required 8000/0000/0", q, r, dz);
        else n_pass++;
        signed_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef SEQ_DIV_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
